// File: rtl/alu_rr_arbiter_if.sv
// Bundles the two requester channels, the ALU operand/result buses and the
// response channel of the round-robin ALU arbiter.
interface alu_rr_arbiter_if #(
   parameter int DATA_W = 4,
   parameter int OP_W   = 2,
   parameter int RES_W  = 5
);
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [OP_W-1:0]   req0_op;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [OP_W-1:0]   req1_op;

   logic [DATA_W-1:0] alu_A;
   logic [DATA_W-1:0] alu_B;
   logic [OP_W-1:0]   alu_opcode;
   logic [RES_W-1:0]  alu_result;
   logic              capture_enable;

   logic              resp_valid;
   logic              resp_id;
   logic [RES_W-1:0]  resp_result;
   logic              resp_ready;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  alu_result, resp_ready,
      output req0_ready, req1_ready,
      output alu_A, alu_B, alu_opcode, capture_enable,
      output resp_valid, resp_id, resp_result
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output alu_result, resp_ready,
      input  req0_ready, req1_ready,
      input  alu_A, alu_B, alu_opcode, capture_enable,
      input  resp_valid, resp_id, resp_result
   );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALU between two requesters;
// the captured result is returned on a response channel tagged with the requester ID.
module alu_rr_arbiter #(
   parameter int DATA_W      = 4,
   parameter int OP_W        = 2,
   parameter int RES_W       = 5,
   parameter int ALU_LATENCY = 1
) (
   input  logic            clk,
   input  logic            reset,
   alu_rr_arbiter_if.slave bus
);
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              last_grant_reg, last_grant_next;
   logic [DATA_W-1:0] alu_a_reg, alu_a_next;
   logic [DATA_W-1:0] alu_b_reg, alu_b_next;
   logic [OP_W-1:0]   alu_op_reg, alu_op_next;
   logic              resp_id_reg, resp_id_next;
   logic [RES_W-1:0]  resp_result_reg, resp_result_next;

   logic [1:0]        req_valid;
   logic [1:0]        ready_vec;
   logic              grant_valid;
   logic              grant_id;
   logic              accept;
   logic              capture;

   assign req_valid = {bus.req1_valid, bus.req0_valid};

   // On a tie the requester that did not win last time is served.
   always_comb begin
      grant_valid = |req_valid;
      grant_id    = 1'b0;
      if (&req_valid)
         grant_id = ~last_grant_reg;
      else
         grant_id = req_valid[1];
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ready
         assign ready_vec[gi] = (state_reg == IDLE) && grant_valid && (grant_id == 1'(gi));
      end
   endgenerate

   assign accept  = (state_reg == IDLE) && grant_valid;
   assign capture = (state_reg == WAIT) && (cnt_reg == CNT_W'(1)) && !reset;

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      last_grant_next  = last_grant_reg;
      alu_a_next       = alu_a_reg;
      alu_b_next       = alu_b_reg;
      alu_op_next      = alu_op_reg;
      resp_id_next     = resp_id_reg;
      resp_result_next = resp_result_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               alu_a_next      = grant_id ? bus.req1_a  : bus.req0_a;
               alu_b_next      = grant_id ? bus.req1_b  : bus.req0_b;
               alu_op_next     = grant_id ? bus.req1_op : bus.req0_op;
               resp_id_next    = grant_id;
               last_grant_next = grant_id;
               cnt_next        = CNT_W'(ALU_LATENCY);
               state_next      = WAIT;
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               resp_result_next = bus.alu_result;
               state_next       = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         last_grant_reg  <= 1'b1;
         alu_a_reg       <= '0;
         alu_b_reg       <= '0;
         alu_op_reg      <= '0;
         resp_id_reg     <= 1'b0;
         resp_result_reg <= '0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         last_grant_reg  <= last_grant_next;
         alu_a_reg       <= alu_a_next;
         alu_b_reg       <= alu_b_next;
         alu_op_reg      <= alu_op_next;
         resp_id_reg     <= resp_id_next;
         resp_result_reg <= resp_result_next;
      end
   end

   assign bus.req0_ready     = ready_vec[0];
   assign bus.req1_ready     = ready_vec[1];
   assign bus.alu_A          = alu_a_reg;
   assign bus.alu_B          = alu_b_reg;
   assign bus.alu_opcode     = alu_op_reg;
   assign bus.capture_enable = capture;
   assign bus.resp_valid     = (state_reg == RESP);
   assign bus.resp_id        = resp_id_reg;
   assign bus.resp_result    = resp_result_reg;
endmodule
